// File: rtl/display_pkg.sv
// Shared definitions for the display sequencer and the status-text block:
// mode codes, digit packing and 7-segment letter glyphs.
package display_pkg;

   localparam logic [1:0] MODE_CORE  = 2'b00;
   localparam logic [1:0] MODE_ALARM = 2'b01;
   localparam logic [1:0] MODE_STOP  = 2'b10;

   localparam int DIGITS  = 6;
   localparam int DIGIT_W = 7;
   localparam int SEG_W   = DIGITS * DIGIT_W;

   localparam logic [6:0] SEG_BLANK = 7'b0;

   // Glyphs are gfedcba, 1 = segment on.
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_C = 7'b0111001;
   localparam logic [6:0] SEG_K = 7'b1110101;
   localparam logic [6:0] SEG_L = 7'b0111000;
   localparam logic [6:0] SEG_M = 7'b0110111;
   localparam logic [6:0] SEG_O = 7'b0111111;
   localparam logic [6:0] SEG_P = 7'b1110011;
   localparam logic [6:0] SEG_R = 7'b1010000;
   localparam logic [6:0] SEG_S = 7'b1101101;
   localparam logic [6:0] SEG_T = 7'b1111000;

   typedef enum logic {
      ST_BANNER = 1'b0,
      ST_SHOW   = 1'b1
   } seq_state_t;

   // Digit 1 is the leftmost and occupies the top slice of the 42-bit bus.
   function automatic int digit_lsb(input int d);
      return (DIGITS - d) * DIGIT_W;
   endfunction

   // Illegal code 11 recovers to core.
   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_CORE:  return MODE_ALARM;
         MODE_ALARM: return MODE_STOP;
         default:    return MODE_CORE;
      endcase
   endfunction

endpackage

// File: rtl/btn_rise_detect.sv
// One-cycle delay register on a debounced level, emitting a rising-edge pulse.
module btn_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_d;

   always_ff @(posedge clk) begin
      if (!rst_n) level_d <= 1'b0;
      else        level_d <= level;
   end

   assign rise = level & ~level_d;

endmodule

// File: rtl/display_sequencer.sv
// Sequences the six-digit display between banner text and live mode digits.
// Optional blinking banner when DISPLAY_SEQ_BLINK_EN is defined.
module display_sequencer
   import display_pkg::*;
#(
   parameter int BANNER_TICKS = 3,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        btn_mode,
   input  logic        mode_lock,
   input  logic [41:0] core_seg,
   input  logic [41:0] alarm_seg,
   input  logic [41:0] stop_seg,
   input  logic [41:0] banner_seg,
   output logic [1:0]  st_mux,
   output logic [6:0]  seg1,
   output logic [6:0]  seg2,
   output logic [6:0]  seg3,
   output logic [6:0]  seg4,
   output logic [6:0]  seg5,
   output logic [6:0]  seg6,
   output logic        banner_active
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BANNER_TICKS - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [41:0]      seg_q;
   logic [41:0]      live_seg;
   logic [41:0]      banner_view;
   logic             rise;
   logic             press;

   btn_rise_detect u_btn_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .level (btn_mode),
      .rise  (rise)
   );

   assign press = rise & ~mode_lock;

   always_comb begin
      live_seg = '0;
      case (st_mux)
         MODE_CORE:  live_seg = core_seg;
         MODE_ALARM: live_seg = alarm_seg;
         MODE_STOP:  live_seg = stop_seg;
         default:    live_seg = '0;
      endcase
   end

`ifdef DISPLAY_SEQ_BLINK_EN
   logic phase;

   always_ff @(posedge clk) begin
      if (!rst_n)
         phase <= 1'b1;
      else if (press)
         phase <= 1'b1;
      else if (state == ST_BANNER && tick)
         phase <= ~phase;
   end

   assign banner_view = phase ? banner_seg : '0;
`else
   assign banner_view = banner_seg;
`endif

   // A press always wins over a coincident tick, so the banner restarts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_mux        <= MODE_CORE;
         state         <= ST_BANNER;
         cnt           <= '0;
         banner_active <= 1'b1;
         seg_q         <= '0;
      end else begin
         banner_active <= (state == ST_BANNER);
         seg_q         <= (state == ST_BANNER) ? banner_view : live_seg;
         if (press) begin
            st_mux <= next_mode(st_mux);
            state  <= ST_BANNER;
            cnt    <= '0;
         end else if (state == ST_BANNER && tick) begin
            if (cnt == CNT_LAST) begin
               state <= ST_SHOW;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign seg1 = seg_q[digit_lsb(1) +: DIGIT_W];
   assign seg2 = seg_q[digit_lsb(2) +: DIGIT_W];
   assign seg3 = seg_q[digit_lsb(3) +: DIGIT_W];
   assign seg4 = seg_q[digit_lsb(4) +: DIGIT_W];
   assign seg5 = seg_q[digit_lsb(5) +: DIGIT_W];
   assign seg6 = seg_q[digit_lsb(6) +: DIGIT_W];

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with a small status-text model.
module tb_display_sequencer;
   import display_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick;
   logic        btn_mode;
   logic        mode_lock;
   logic [41:0] core_seg;
   logic [41:0] alarm_seg;
   logic [41:0] stop_seg;
   logic [41:0] banner_seg;
   logic [1:0]  st_mux;
   logic [6:0]  seg1, seg2, seg3, seg4, seg5, seg6;
   logic        banner_active;
   logic [41:0] disp;

   int total = 0;
   int bad   = 0;

   localparam logic [41:0] TXT_CLOCK = {SEG_C, SEG_L, SEG_O, SEG_C, SEG_K, SEG_BLANK};
   localparam logic [41:0] TXT_ALARM = {SEG_A, SEG_L, SEG_A, SEG_R, SEG_M, SEG_BLANK};
   localparam logic [41:0] TXT_STOP  = {SEG_S, SEG_T, SEG_O, SEG_P, SEG_BLANK, SEG_BLANK};

   always #5 clk = ~clk;

   display_sequencer #(.BANNER_TICKS(3), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .btn_mode      (btn_mode),
      .mode_lock     (mode_lock),
      .core_seg      (core_seg),
      .alarm_seg     (alarm_seg),
      .stop_seg      (stop_seg),
      .banner_seg    (banner_seg),
      .st_mux        (st_mux),
      .seg1          (seg1),
      .seg2          (seg2),
      .seg3          (seg3),
      .seg4          (seg4),
      .seg5          (seg5),
      .seg6          (seg6),
      .banner_active (banner_active)
   );

   // Status-block model: text follows st_mux combinationally.
   always_comb begin
      banner_seg = '0;
      case (st_mux)
         2'b00:   banner_seg = TXT_CLOCK;
         2'b01:   banner_seg = TXT_ALARM;
         2'b10:   banner_seg = TXT_STOP;
         default: banner_seg = '0;
      endcase
   end

   assign disp = {seg1, seg2, seg3, seg4, seg5, seg6};

   task automatic check(input string tag, input logic [41:0] got, input logic [41:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs set before step are captured at the next edge; outputs are read 1ns later.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic press();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      tick      = 1'b0;
      btn_mode  = 1'b0;
      mode_lock = 1'b0;
      core_seg  = 42'h0ABCDEF0123;
      alarm_seg = 42'h123456789AB;
      stop_seg  = 42'h2AAAA555555;
      step(2);
      check("rst_mux", {40'b0, st_mux}, 42'd0);
      check("rst_seg", disp, 42'd0);
      check("rst_active", {41'b0, banner_active}, 42'd1);

      rst_n = 1'b1;
      step();
      check("boot_banner", disp, TXT_CLOCK);
      pulse_tick();
      step();
`ifdef DISPLAY_SEQ_BLINK_EN
      check("blink_off", disp, 42'd0);
`else
      check("steady_1", disp, TXT_CLOCK);
`endif
      pulse_tick();
      step();
      check("steady_2", disp, TXT_CLOCK);
      pulse_tick();
      check("active_lag", {41'b0, banner_active}, 42'd1);
      step();
      check("show_active", {41'b0, banner_active}, 42'd0);
      check("show_core", disp, 42'h0ABCDEF0123);
      check("show_mux", {40'b0, st_mux}, 42'd0);

      press();
      check("press_mux", {40'b0, st_mux}, 42'd1);
      step();
      check("alarm_active", {41'b0, banner_active}, 42'd1);
      check("alarm_banner", disp, TXT_ALARM);
      pulse_tick();
      pulse_tick();
      pulse_tick();
      step();
      check("alarm_show", disp, 42'h123456789AB);
      check("alarm_show_act", {41'b0, banner_active}, 42'd0);

      press();
      step();
      check("rot_stop", {40'b0, st_mux}, 42'd2);
      press();
      step();
      check("rot_core", {40'b0, st_mux}, 42'd0);
      pulse_tick();
      pulse_tick();
      pulse_tick();
      step();
      check("core_again", disp, 42'h0ABCDEF0123);

      mode_lock = 1'b1;
      btn_mode  = 1'b1;
      step();
      mode_lock = 1'b0;
      step(3);
      check("lock_mux", {40'b0, st_mux}, 42'd0);
      check("lock_state", {41'b0, banner_active}, 42'd0);
      btn_mode = 1'b0;
      step();

      btn_mode = 1'b1;
      step(20);
      btn_mode = 1'b0;
      step();
      check("hold_mux", {40'b0, st_mux}, 42'd1);

      pulse_tick();
      pulse_tick();
      tick     = 1'b1;
      btn_mode = 1'b1;
      step();
      tick     = 1'b0;
      btn_mode = 1'b0;
      step();
      check("coinc_mux", {40'b0, st_mux}, 42'd2);
      check("coinc_active", {41'b0, banner_active}, 42'd1);
      check("coinc_banner", disp, TXT_STOP);
      pulse_tick();
      pulse_tick();
      step();
      check("coinc_hold", {41'b0, banner_active}, 42'd1);
      pulse_tick();
      step();
      check("coinc_exit", {41'b0, banner_active}, 42'd0);
      check("stop_show", disp, 42'h2AAAA555555);

      rst_n = 1'b0;
      tick  = 1'b1;
      step();
      rst_n = 1'b1;
      tick  = 1'b0;
      check("mid_rst_mux", {40'b0, st_mux}, 42'd0);
      check("mid_rst_seg", disp, 42'd0);
      check("mid_rst_act", {41'b0, banner_active}, 42'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Owns the six-digit 7-segment display and sequences it between the three clock modes: core clock, alarm and stopwatch.
- Each mode press advances the mode and drives st_mux to the status-text block. The returned banner is shown for a fixed number of ticks, then the display switches to the selected mode's live digits.
- Sits between the mode button / tick generator and the display pins.

Parameters:
- BANNER_TICKS, 3: tick pulses the banner is held after a mode change or reset; legal range 1..15.
- CNT_W, 4: width of the banner tick counter; must hold BANNER_TICKS.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- tick  input  1  one-cycle enable pulse from the timebase (1 Hz nominal)
- btn_mode  input  1  debounced mode-button level; active high
- mode_lock  input  1  when high, mode presses are ignored (set-time in progress)
- core_seg  input  42  live core-clock digits; [41:35]=digit1 .. [6:0]=digit6
- alarm_seg  input  42  live alarm digits, same packing
- stop_seg  input  42  live stopwatch digits, same packing
- banner_seg  input  42  status text returned by the status block for the current st_mux, same packing
- st_mux  output  2  mode select to the status block: 00 core, 01 alarm, 10 stop
- seg1..seg6  output  7 each  registered segment drive, 1 = segment on
- banner_active  output  1  high while the banner is displayed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset values: st_mux=00, state=BANNER, cnt=0, banner_active=1, seg1..seg6=7'b0, edge register=0.
- Press detection: rising edge of btn_mode, taken from a one-cycle-delayed copy. A press is valid only if mode_lock=0 in that cycle. Holding the button gives exactly one press.
- Mode rotation on a valid press: 00 -> 01 -> 10 -> 00. Code 11 is never produced; if st_mux is ever 11, the next press or reset forces 00.
- State machine: two states, BANNER and SHOW.
- BANNER:
  - cnt increments on each tick.
  - When cnt==BANNER_TICKS-1 and tick=1, go to SHOW and clear cnt.
  - A valid press advances the mode and sets cnt=0; the state stays BANNER.
- SHOW:
  - A valid press advances the mode, goes to BANNER and sets cnt=0.
  - tick has no effect.
- Simultaneous press and tick in the same cycle: the press wins, cnt=0, no exit to SHOW.
- Segment source, registered (1-cycle latency from the inputs):
  - BANNER: banner_seg.
  - SHOW: the live digits selected by st_mux (core/alarm/stop_seg).
- Feedback timing: st_mux is registered, so banner_seg reflects the new mode one cycle after the press. The segment register therefore shows stale text for at most 1 cycle; that is acceptable.
- banner_active equals (state==BANNER), registered alongside the segments.
- Reset mid-banner or mid-SHOW returns to the reset values on the next edge, regardless of tick or press.
- mode_lock rising during BANNER does not freeze cnt; the banner still expires.

Optional Feature:
- Macro: DISPLAY_SEQ_BLINK_EN.
- Defined:
  - A blink phase register toggles on every tick while in BANNER; it is forced to 1 on entry to BANNER and on reset.
  - In BANNER, the segments show banner_seg when phase=1 and all-blank (7'b0 each digit) when phase=0.
  - SHOW is unaffected.
- Undefined: no phase register; the banner is shown steadily.

Decomposition:
- Shared package display_pkg holds:
  - mode codes MODE_CORE=2'b00, MODE_ALARM=2'b01, MODE_STOP=2'b10;
  - the SEG_BLANK=7'b0 constant;
  - the 42-bit digit-packing slice positions;
  - the letter segment constants used by the status block.
- One sub-module: btn_rise_detect (1-bit delay register plus rising-edge output, synchronous active-low reset). It is instantiated once for btn_mode.

Test Plan:
- Release reset, pulse tick 3 times -> seg = CLOCK banner for 3 ticks. banner_active drops 1 cycle after the 3rd tick. Then seg = core_seg (set to 42'h0ABCDEF0123), st_mux=00.
- In SHOW, press btn_mode -> st_mux=01 next cycle, banner_active=1, ALARM banner for 3 ticks, then alarm_seg. Three presses total -> st_mux sequence 01, 10, 00.
- Press with mode_lock=1 -> st_mux unchanged, state unchanged. Hold btn_mode high for 20 cycles -> only one advance.
- Press coincident with the 3rd banner tick -> stays in BANNER, mode advances, exit requires 3 further ticks.
- Assert rst_n=0 for one cycle during SHOW in stop mode -> st_mux=00, seg=0, banner_active=1 after the edge.
- With DISPLAY_SEQ_BLINK_EN defined, BANNER_TICKS=3 -> segments show banner, blank, banner on successive tick intervals. Without it -> steady banner.
